arb_req_agent: RTL

- Master-side requester that pairs with the 4-input fixed-priority arbiter.
- Holds one pending command per master (0..3) and drives arb_req0..arb_req3 from those commands.
- Watches the registered encoded grant and, when granted, locks ownership and streams the owner's burst of beats downstream.
- Releases the request after the last beat, then inserts one idle gap cycle so the stale registered grant is never reused.

---
 rtl/arb_req_agent.sv | 93 +++++++++
 1 files changed

// File: rtl/arb_req_agent.sv
// arb_req_agent: per-master command holder that requests a 4-input arbiter and streams the granted burst
module arb_req_agent #(
  parameter int LEN_W = 4
) (
  input  logic               arb_clk,
  input  logic               arb_rst_n,
  input  logic [3:0]         cmd_valid,
  output logic [3:0]         cmd_ready,
  input  logic [4*LEN_W-1:0] cmd_len,
  output logic               arb_req0,
  output logic               arb_req1,
  output logic               arb_req2,
  output logic               arb_req3,
  input  logic [1:0]         arb_gnt,
  input  logic               arb_gnt_vld,
  output logic               xfer_valid,
  input  logic               xfer_ready,
  output logic [1:0]         xfer_id,
  output logic [LEN_W-1:0]   xfer_beat,
  output logic               xfer_last,
  output logic [3:0]         done
);
  typedef enum logic [1:0] {IDLE, BURST, GAP} state_t;
  state_t                  state_q, state_d;
  logic [3:0]              pending_q, pending_d;
  logic [3:0]              done_q, done_d;
  logic [3:0][LEN_W-1:0]   len_q, len_d;
  logic [1:0]              owner_q, owner_d;
  logic [LEN_W-1:0]        beat_q, beat_d;
  logic                    last;
  assign last       = beat_q == len_q[owner_q];
  assign cmd_ready  = ~pending_q;
  assign {arb_req3, arb_req2, arb_req1, arb_req0} = pending_q;
  assign xfer_valid = state_q == BURST;
  assign xfer_id    = xfer_valid ? owner_q : '0;
  assign xfer_beat  = xfer_valid ? beat_q : '0;
  assign xfer_last  = xfer_valid && last;
  assign done       = done_q;
  // command capture plus IDLE/BURST/GAP sequencing; the owner is locked until its last beat
  always_comb begin
    state_d   = state_q;
    pending_d = pending_q;
    len_d     = len_q;
    owner_d   = owner_q;
    beat_d    = beat_q;
    done_d    = '0;
    for (int i = 0; i < 4; i++) begin
      if (cmd_valid[i] && !pending_q[i]) begin
        pending_d[i] = 1'b1;
        len_d[i]     = cmd_len[i*LEN_W +: LEN_W];
      end
    end
    case (state_q)
      IDLE: begin
        if (arb_gnt_vld && pending_q[arb_gnt]) begin
          owner_d = arb_gnt;
          beat_d  = '0;
          state_d = BURST;
        end
      end
      BURST: begin
        if (xfer_ready) begin
          if (last) begin
            pending_d[owner_q] = 1'b0;
            done_d[owner_q]    = 1'b1;
            state_d            = GAP;
          end else begin
            beat_d = beat_q + 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end
  // state registers, cleared immediately on reset so a partial burst is dropped
  always_ff @(posedge arb_clk or negedge arb_rst_n) begin
    if (!arb_rst_n) begin
      state_q   <= IDLE;
      pending_q <= '0;
      done_q    <= '0;
      len_q     <= '0;
      owner_q   <= '0;
      beat_q    <= '0;
    end else begin
      state_q   <= state_d;
      pending_q <= pending_d;
      done_q    <= done_d;
      len_q     <= len_d;
      owner_q   <= owner_d;
      beat_q    <= beat_d;
    end
  end
endmodule
